// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller port bundle between the pipeline stages and pipe_hazard_ctrl.
// master = pipeline side that drives stage info; slave = the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_is_md;
    logic              id_rd_hilo;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wen;
    logic              ex_is_load;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_wen;
    logic              ex_br_taken;
    logic              md_done;
    logic              stall_pc;
    logic              bubble_ex;
    logic              flush_id;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              md_start;
    logic              md_busy;
    logic              md_err;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_rd_hilo,
               ex_rd, ex_wen, ex_is_load, mem_rd, mem_wen, ex_br_taken, md_done,
        input  stall_pc, bubble_ex, flush_id, fwd_a, fwd_b, md_start, md_busy,
               md_err, cyc_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_rd_hilo,
               ex_rd, ex_wen, ex_is_load, mem_rd, mem_wen, ex_br_taken, md_done,
        output stall_pc, bubble_ex, flush_id, fwd_a, fwd_b, md_start, md_busy,
               md_err, cyc_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding control and MUL/DIV sequencing for the 5-stage MIPS pipeline.
// Optional performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MD_MAX_CYC = 40,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz
);
    localparam int WD_W = $clog2(MD_MAX_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYC - 1);
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ERR  = 2'b10
    } md_state_t;

    md_state_t       state_r, state_nxt_s;
    logic [WD_W-1:0] wd_r, wd_nxt_s;
    logic            err_r, err_nxt_s;
    logic            lu_s, mdh_s;
    logic            stall_pc_s, bubble_ex_s, flush_id_s, md_start_s;
    logic [1:0]      fwd_a_s, fwd_b_s;
    logic            ex_fwd_ok_s, mem_fwd_ok_s;

    // Operand forwarding selects; a load in EX has no result yet, so it never forwards
    always_comb begin
        ex_fwd_ok_s  = hz.ex_wen && !hz.ex_is_load && (hz.ex_rd != REG_ZERO);
        mem_fwd_ok_s = hz.mem_wen && (hz.mem_rd != REG_ZERO);
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (ex_fwd_ok_s && (hz.ex_rd == hz.id_rs)) begin
            fwd_a_s = 2'b01;
        end else if (mem_fwd_ok_s && (hz.mem_rd == hz.id_rs)) begin
            fwd_a_s = 2'b10;
        end else begin
            fwd_a_s = 2'b00;
        end
        if (ex_fwd_ok_s && (hz.ex_rd == hz.id_rt)) begin
            fwd_b_s = 2'b01;
        end else if (mem_fwd_ok_s && (hz.mem_rd == hz.id_rt)) begin
            fwd_b_s = 2'b10;
        end else begin
            fwd_b_s = 2'b00;
        end
    end

    // Stall/bubble/flush decision; a taken branch kills the ID instruction, so it wins
    always_comb begin
        lu_s = hz.ex_is_load && hz.ex_wen && (hz.ex_rd != REG_ZERO) &&
               ((hz.id_use_rs && (hz.ex_rd == hz.id_rs)) ||
                (hz.id_use_rt && (hz.ex_rd == hz.id_rt)));
        mdh_s = (state_r != ST_IDLE) && (state_r != ST_ERR) && (hz.id_is_md || hz.id_rd_hilo);
        stall_pc_s  = 1'b0;
        bubble_ex_s = 1'b0;
        flush_id_s  = 1'b0;
        if (hz.ex_br_taken) begin
            flush_id_s  = 1'b1;
            bubble_ex_s = 1'b1;
        end else if (lu_s || mdh_s) begin
            stall_pc_s  = 1'b1;
            bubble_ex_s = 1'b1;
        end else begin
            stall_pc_s  = 1'b0;
        end
    end

    // MUL/DIV sequencer next state; ERR issues like IDLE but the error flag stays set
    always_comb begin
        state_nxt_s = state_r;
        wd_nxt_s    = wd_r;
        err_nxt_s   = err_r;
        md_start_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (hz.id_is_md && !stall_pc_s && !hz.ex_br_taken) begin
                    md_start_s  = 1'b1;
                    state_nxt_s = ST_BUSY;
                    wd_nxt_s    = {WD_W{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_BUSY: begin
                if (hz.md_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (wd_r == WD_LAST) begin
                    state_nxt_s = ST_ERR;
                    err_nxt_s   = 1'b1;
                end else begin
                    wd_nxt_s = wd_r + {{(WD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, watchdog and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            wd_r    <= {WD_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wd_r    <= wd_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign hz.stall_pc  = stall_pc_s;
    assign hz.bubble_ex = bubble_ex_s;
    assign hz.flush_id  = flush_id_s;
    assign hz.fwd_a     = fwd_a_s;
    assign hz.fwd_b     = fwd_b_s;
    assign hz.md_start  = md_start_s;
    assign hz.md_busy   = (state_r == ST_BUSY);
    assign hz.md_err    = err_r;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] cyc_cnt_r, stall_cnt_r, flush_cnt_r;

    // Free-running statistics, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_r   <= {CNT_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cyc_cnt_r   <= cyc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, stall_pc_s};
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, flush_id_s};
        end
    end

    assign hz.cyc_cnt   = cyc_cnt_r;
    assign hz.stall_cnt = stall_cnt_r;
    assign hz.flush_cnt = flush_cnt_r;
`else
    assign hz.cyc_cnt   = {CNT_W{1'b0}};
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule
